tl_ul_multiport_monitor: RTL and testbench

- Parametrised N-port TileLink-UL protocol checker for the testbench. It supersedes fixed two-instance monitor wrappers.
- Passively observes the A and D channels of NUM_PORTS independent TL-UL links. It tracks in-flight requests per source ID and enforces handshake stability, field legality, request/response pairing and a response timeout.
- Errors are reported as sticky per-port flags plus a first-error capture, for bench scoreboards and end-of-test checks.
- Drives no DUT signals.

---
 rtl/tl_ul_multiport_monitor.sv | 189 ++++++++++++++++++
 tb/tb_tl_ul_multiport_monitor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_multiport_monitor.sv
// Passive N-port TL-UL checker: per-source pending tracking, sticky per-port error flags, first-error capture.
// Errors register one cycle after the offending cycle; observes only, so it never applies backpressure.
module tl_ul_multiport_monitor #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int SOURCE_W       = 2,
  parameter int SIZE_W         = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int BYTES         = DATA_W / 8,
  localparam int PORT_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             a_valid,
  input  logic [NUM_PORTS-1:0]             a_ready,
  input  logic [3*NUM_PORTS-1:0]           a_opcode,
  input  logic [SIZE_W*NUM_PORTS-1:0]      a_size,
  input  logic [SOURCE_W*NUM_PORTS-1:0]    a_source,
  input  logic [ADDR_W*NUM_PORTS-1:0]      a_address,
  input  logic [BYTES*NUM_PORTS-1:0]       a_mask,
  input  logic [NUM_PORTS-1:0]             d_valid,
  input  logic [NUM_PORTS-1:0]             d_ready,
  input  logic [3*NUM_PORTS-1:0]           d_opcode,
  input  logic [SOURCE_W*NUM_PORTS-1:0]    d_source,
  input  logic                             err_clear,
  output logic [9*NUM_PORTS-1:0]           err_flags,
  output logic                             err_any,
  output logic                             first_err_valid,
  output logic [PORT_W-1:0]                first_err_port,
  output logic [3:0]                       first_err_code,
  output logic [(SOURCE_W+1)*NUM_PORTS-1:0] inflight_cnt
);
  localparam int LOG_BYTES = $clog2(BYTES);
  localparam int NSRC      = 1 << SOURCE_W;
  localparam int CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  // Byte lanes a naturally aligned access of 2^size bytes may touch on this bus.
  function automatic logic [BYTES-1:0] lane_mask(input logic [SIZE_W-1:0] size,
                                                  input logic [ADDR_W-1:0] addr);
    int nb;
    int off;
    logic [BYTES-1:0] m;
    nb  = 1 << size;
    off = int'(addr & ADDR_W'(BYTES - 1));
    off = off & ~(nb - 1);
    m   = '0;
    for (int i = 0; i < BYTES; i++) m[i] = (i >= off) && (i < off + nb);
    return m;
  endfunction

  logic [9*NUM_PORTS-1:0] err_new;
  logic [PORT_W-1:0]      fe_port;
  logic [3:0]             fe_code;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic                a_fire, d_fire, same_src, get_eff, tmo;
    logic [2:0]          a_op, d_op, a_op_h, d_op_h;
    logic [SIZE_W-1:0]   a_sz, a_sz_h;
    logic [SOURCE_W-1:0] a_src, d_src, a_src_h, d_src_h;
    logic [ADDR_W-1:0]   a_addr, a_addr_h;
    logic [BYTES-1:0]    a_msk, a_msk_h, exp_msk;
    logic                a_hold, d_hold;
    logic [NSRC-1:0]     pend, pend_get, pend_nxt, get_nxt;
    logic [SOURCE_W:0]   inflight_q, inflight_nxt;
    logic [8:0]          err;

    assign a_op     = a_opcode[3*p +: 3];
    assign a_sz     = a_size[SIZE_W*p +: SIZE_W];
    assign a_src    = a_source[SOURCE_W*p +: SOURCE_W];
    assign a_addr   = a_address[ADDR_W*p +: ADDR_W];
    assign a_msk    = a_mask[BYTES*p +: BYTES];
    assign d_op     = d_opcode[3*p +: 3];
    assign d_src    = d_source[SOURCE_W*p +: SOURCE_W];
    assign a_fire   = a_valid[p] & a_ready[p];
    assign d_fire   = d_valid[p] & d_ready[p];
    assign same_src = a_fire && d_fire && (a_src == d_src);
    assign exp_msk  = lane_mask(a_sz, a_addr);

    always_comb begin
      err     = '0;
      err[0]  = a_hold && (!a_valid[p] || a_op != a_op_h || a_sz != a_sz_h ||
                           a_src != a_src_h || a_addr != a_addr_h || a_msk != a_msk_h);
      err[1]  = d_hold && (!d_valid[p] || d_op != d_op_h || d_src != d_src_h);
      err[2]  = a_valid[p] && (!(a_op inside {OP_PUT_FULL, OP_PUT_PART, OP_GET}) ||
                               int'(a_sz) > LOG_BYTES);
      err[3]  = a_valid[p] && ((a_addr & ~({ADDR_W{1'b1}} << a_sz)) != '0);
      if (a_valid[p]) begin
        if (a_op == OP_PUT_PART)
          err[4] = (a_msk & ~exp_msk) != '0;
        else if (a_op == OP_PUT_FULL || a_op == OP_GET)
          err[4] = a_msk != exp_msk;
      end
      err[5]  = a_fire && pend[a_src] && !same_src;
      err[6]  = d_fire && !pend[d_src] && !same_src;
      // A zero-latency response answers the request presented in the same cycle.
      get_eff = (same_src && !pend[d_src]) ? (a_op == OP_GET) : pend_get[d_src];
      err[7]  = d_valid[p] && (d_op != (get_eff ? OP_ACK_DATA : OP_ACK));
      err[8]  = tmo;
    end

    always_comb begin
      pend_nxt     = pend;
      get_nxt      = pend_get;
      inflight_nxt = '0;
      if (d_fire) pend_nxt[d_src] = 1'b0;
      if (a_fire && !(same_src && !pend[a_src])) begin
        pend_nxt[a_src] = 1'b1;
        get_nxt[a_src]  = (a_op == OP_GET);
      end
      for (int i = 0; i < NSRC; i++) inflight_nxt = inflight_nxt + (SOURCE_W+1)'(pend_nxt[i]);
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        pend       <= '0;
        pend_get   <= '0;
        a_hold     <= 1'b0;
        d_hold     <= 1'b0;
        inflight_q <= '0;
      end else begin
        pend       <= pend_nxt;
        pend_get   <= get_nxt;
        a_hold     <= a_valid[p] & ~a_ready[p];
        d_hold     <= d_valid[p] & ~d_ready[p];
        inflight_q <= inflight_nxt;
      end
    end

    always_ff @(posedge clock) begin
      a_op_h   <= a_op;
      a_sz_h   <= a_sz;
      a_src_h  <= a_src;
      a_addr_h <= a_addr;
      a_msk_h  <= a_msk;
      d_op_h   <= d_op;
      d_src_h  <= d_src;
    end

    if (TIMEOUT_CYCLES > 0) begin : g_tmo
      logic [CNT_W-1:0] tcnt;
      always_ff @(posedge clock) begin
        if (reset || d_fire || pend == '0) tcnt <= '0;
        else if (tcnt != CNT_W'(TIMEOUT_CYCLES)) tcnt <= tcnt + CNT_W'(1);
      end
      assign tmo = (tcnt == CNT_W'(TIMEOUT_CYCLES));
    end else begin : g_no_tmo
      assign tmo = 1'b0;
    end

    assign err_new[9*p +: 9] = err;
    assign inflight_cnt[(SOURCE_W+1)*p +: SOURCE_W+1] = inflight_q;
  end

  // Descending scan so the lowest port, then lowest bit, is the last to win.
  always_comb begin
    fe_port = '0;
    fe_code = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--)
      for (int b = 8; b >= 0; b--)
        if (err_new[9*p + b]) begin
          fe_port = PORT_W'(p);
          fe_code = 4'(b);
        end
  end

  always_ff @(posedge clock) begin
    if (reset || err_clear) begin
      err_flags       <= '0;
      first_err_valid <= 1'b0;
      first_err_port  <= '0;
      first_err_code  <= '0;
    end else begin
      err_flags <= err_flags | err_new;
      if (!first_err_valid && err_new != '0) begin
        first_err_valid <= 1'b1;
        first_err_port  <= fe_port;
        first_err_code  <= fe_code;
      end
    end
  end

  assign err_any = |err_flags;
endmodule

// File: tb/tb_tl_ul_multiport_monitor.sv
// Directed bench for tl_ul_multiport_monitor: two ports, 32-bit bus, timeout 16 (plus a timeout-disabled copy).
module tb_tl_ul_multiport_monitor;
  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  a_valid, a_ready, d_valid, d_ready;
  logic [5:0]  a_opcode, d_opcode;
  logic [3:0]  a_size, a_source, d_source;
  logic [63:0] a_address;
  logic [7:0]  a_mask;
  logic        err_clear;
  logic [17:0] err_flags, err_flags_z;
  logic        err_any, err_any_z, fev, fev_z;
  logic [0:0]  fep, fep_z;
  logic [3:0]  fec, fec_z;
  logic [5:0]  infl, infl_z;
  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  tl_ul_multiport_monitor #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .SOURCE_W(2), .SIZE_W(2),
                            .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_source(d_source),
    .err_clear(err_clear), .err_flags(err_flags), .err_any(err_any), .first_err_valid(fev),
    .first_err_port(fep), .first_err_code(fec), .inflight_cnt(infl));

  tl_ul_multiport_monitor #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .SOURCE_W(2), .SIZE_W(2),
                            .TIMEOUT_CYCLES(0)) dut_no_tmo (
    .clock(clock), .reset(reset), .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_source(d_source),
    .err_clear(err_clear), .err_flags(err_flags_z), .err_any(err_any_z), .first_err_valid(fev_z),
    .first_err_port(fep_z), .first_err_code(fec_z), .inflight_cnt(infl_z));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input int p, input logic v, input logic r, input logic [2:0] op,
                       input logic [1:0] sz, input logic [1:0] src, input logic [31:0] adr,
                       input logic [3:0] msk);
    a_valid[p] = v;
    a_ready[p] = r;
    a_opcode[3*p +: 3] = op;
    a_size[2*p +: 2] = sz;
    a_source[2*p +: 2] = src;
    a_address[32*p +: 32] = adr;
    a_mask[4*p +: 4] = msk;
  endtask

  task automatic set_d(input int p, input logic v, input logic r, input logic [2:0] op,
                       input logic [1:0] src);
    d_valid[p] = v;
    d_ready[p] = r;
    d_opcode[3*p +: 3] = op;
    d_source[2*p +: 2] = src;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      set_a(p, 1'b0, 1'b0, 3'd0, 2'd0, 2'd0, 32'h0, 4'h0);
      set_d(p, 1'b0, 1'b0, 3'd0, 2'd0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    vectors++; if (err_flags !== 18'h0) begin miscompares++; $display("FAIL reset_flags: got %h want 0", err_flags); end
    vectors++; if (err_any !== 1'b0) begin miscompares++; $display("FAIL reset_any: got %b want 0", err_any); end
    vectors++; if ({fev, fep, fec} !== 6'h0) begin miscompares++; $display("FAIL reset_first: got %b want 0", {fev, fep, fec}); end
    vectors++; if (infl !== 6'h0) begin miscompares++; $display("FAIL reset_inflight: got %h want 0", infl); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    set_a(0, 1'b1, 1'b1, 3'd4, 2'd2, 2'd1, 32'h100, 4'hF);
    tick();
    idle();
    vectors++; if (infl[2:0] !== 3'd1) begin miscompares++; $display("FAIL basic_infl1: got %0d want 1", infl[2:0]); end
    tick();
    tick();
    vectors++; if (infl[2:0] !== 3'd1) begin miscompares++; $display("FAIL basic_infl_hold: got %0d want 1", infl[2:0]); end
    set_d(0, 1'b1, 1'b1, 3'd1, 2'd1);
    tick();
    idle();
    vectors++; if (infl[2:0] !== 3'd0) begin miscompares++; $display("FAIL basic_infl0: got %0d want 0", infl[2:0]); end
    vectors++; if (err_flags !== 18'h0) begin miscompares++; $display("FAIL basic_flags: got %h want 0", err_flags); end
    // PutPartial of two bytes at 0x2 with lane 2 only is a legal subset of 0xC
    set_a(0, 1'b1, 1'b1, 3'd1, 2'd1, 2'd2, 32'h2, 4'h4);
    tick();
    idle();
    set_d(0, 1'b1, 1'b1, 3'd0, 2'd2);
    tick();
    idle();
    vectors++; if (err_flags !== 18'h0 || infl !== 6'h0) begin miscompares++; $display("FAIL basic_partial: got %h/%h want 0/0", err_flags, infl); end
  endtask

  task automatic test_unstable();
    do_reset();
    set_a(1, 1'b1, 1'b0, 3'd4, 2'd2, 2'd0, 32'h40, 4'hF);
    tick();
    vectors++; if (err_flags !== 18'h0) begin miscompares++; $display("FAIL unst_first_cycle: got %h want 0", err_flags); end
    set_a(1, 1'b1, 1'b0, 3'd4, 2'd2, 2'd0, 32'h44, 4'hF);
    tick();
    vectors++; if (err_flags !== 18'h200) begin miscompares++; $display("FAIL unst_a_flag: got %h want 00200", err_flags); end
    vectors++; if ({fev, fep, fec} !== {1'b1, 1'b1, 4'd0}) begin miscompares++; $display("FAIL unst_first: got %b want 110000", {fev, fep, fec}); end
    set_a(1, 1'b1, 1'b1, 3'd4, 2'd2, 2'd0, 32'h44, 4'hF);
    tick();
    idle();
    vectors++; if (err_flags !== 18'h200) begin miscompares++; $display("FAIL unst_sticky: got %h want 00200", err_flags); end
    set_d(0, 1'b1, 1'b0, 3'd0, 2'd0);
    tick();
    idle();
    tick();
    vectors++; if (err_flags !== 18'h202) begin miscompares++; $display("FAIL unst_d_flag: got %h want 00202", err_flags); end
    vectors++; if ({fev, fep, fec} !== {1'b1, 1'b1, 4'd0}) begin miscompares++; $display("FAIL unst_first_frozen: got %b want 110000", {fev, fep, fec}); end
  endtask

  task automatic test_align_mask();
    do_reset();
    set_a(0, 1'b1, 1'b1, 3'd0, 2'd2, 2'd0, 32'h102, 4'hC);
    tick();
    idle();
    vectors++; if (err_flags !== 18'h018) begin miscompares++; $display("FAIL align_flags: got %h want 00018", err_flags); end
    vectors++; if ({fev, fep, fec} !== {1'b1, 1'b0, 4'd3}) begin miscompares++; $display("FAIL align_first: got %b want 100011", {fev, fep, fec}); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    set_a(0, 1'b1, 1'b1, 3'd1, 2'd1, 2'd1, 32'h2, 4'h3);
    tick();
    idle();
    vectors++; if (err_flags !== 18'h010 || fec !== 4'd4) begin miscompares++; $display("FAIL partial_mask: got %h/%0d want 00010/4", err_flags, fec); end
  endtask

  task automatic test_opcode_priority();
    do_reset();
    set_a(0, 1'b1, 1'b1, 3'd0, 2'd2, 2'd0, 32'h100, 4'h7);
    set_a(1, 1'b1, 1'b1, 3'd3, 2'd2, 2'd0, 32'h0, 4'hF);
    tick();
    idle();
    vectors++; if (err_flags !== 18'h810) begin miscompares++; $display("FAIL prio_flags: got %h want 00810", err_flags); end
    vectors++; if ({fev, fep, fec} !== {1'b1, 1'b0, 4'd4}) begin miscompares++; $display("FAIL prio_first: got %b want 100100", {fev, fep, fec}); end
    set_a(0, 1'b1, 1'b1, 3'd4, 2'd3, 2'd1, 32'h0, 4'hF);
    tick();
    idle();
    vectors++; if (err_flags !== 18'h814) begin miscompares++; $display("FAIL size_flags: got %h want 00814", err_flags); end
    vectors++; if ({fev, fep, fec} !== {1'b1, 1'b0, 4'd4}) begin miscompares++; $display("FAIL size_first_frozen: got %b want 100100", {fev, fep, fec}); end
  endtask

  task automatic test_dup_noreq_clear();
    do_reset();
    set_a(0, 1'b1, 1'b1, 3'd4, 2'd2, 2'd2, 32'h0, 4'hF);
    tick();
    vectors++; if (err_flags !== 18'h0 || infl[2:0] !== 3'd1) begin miscompares++; $display("FAIL dup_first: got %h/%0d want 0/1", err_flags, infl[2:0]); end
    tick();
    idle();
    vectors++; if (err_flags !== 18'h020 || infl[2:0] !== 3'd1) begin miscompares++; $display("FAIL dup_flag: got %h/%0d want 00020/1", err_flags, infl[2:0]); end
    set_d(0, 1'b1, 1'b1, 3'd0, 2'd3);
    tick();
    idle();
    vectors++; if (err_flags !== 18'h060) begin miscompares++; $display("FAIL noreq_flag: got %h want 00060", err_flags); end
    vectors++; if ({fev, fep, fec} !== {1'b1, 1'b0, 4'd5}) begin miscompares++; $display("FAIL noreq_first: got %b want 100101", {fev, fep, fec}); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    vectors++; if (err_flags !== 18'h0 || err_any !== 1'b0 || fev !== 1'b0) begin miscompares++; $display("FAIL clear: got %h/%b/%b want 0/0/0", err_flags, err_any, fev); end
    err_clear = 1'b1;
    set_a(1, 1'b1, 1'b0, 3'd3, 2'd2, 2'd0, 32'h0, 4'hF);
    tick();
    err_clear = 1'b0;
    vectors++; if (err_flags !== 18'h0) begin miscompares++; $display("FAIL clear_wins: got %h want 0", err_flags); end
    set_a(1, 1'b1, 1'b1, 3'd3, 2'd2, 2'd0, 32'h0, 4'hF);
    tick();
    idle();
    vectors++; if (err_flags !== 18'h800 || {fev, fep, fec} !== {1'b1, 1'b1, 4'd2}) begin miscompares++; $display("FAIL reflag: got %h/%b want 00800/110010", err_flags, {fev, fep, fec}); end
  endtask

  task automatic test_timeout();
    do_reset();
    set_a(0, 1'b1, 1'b1, 3'd4, 2'd2, 2'd1, 32'h20, 4'hF);
    tick();
    idle();
    for (int i = 1; i <= 16; i++) begin
      tick();
      vectors++; if (err_flags[8] !== 1'b0) begin miscompares++; $display("FAIL tmo_early: cycle %0d got 1 want 0", i); end
    end
    tick();
    vectors++; if (err_flags !== 18'h100) begin miscompares++; $display("FAIL tmo_flag: got %h want 00100", err_flags); end
    vectors++; if ({fev, fep, fec} !== {1'b1, 1'b0, 4'd8}) begin miscompares++; $display("FAIL tmo_first: got %b want 101000", {fev, fep, fec}); end
    vectors++; if (err_flags_z !== 18'h0 || err_any_z !== 1'b0) begin miscompares++; $display("FAIL tmo_disabled: got %h want 0", err_flags_z); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_a(0, 1'b1, 1'b1, 3'd4, 2'd2, 2'd0, 32'h0, 4'hF);
    tick();
    set_a(0, 1'b1, 1'b1, 3'd4, 2'd2, 2'd1, 32'h4, 4'hF);
    tick();
    idle();
    vectors++; if (infl[2:0] !== 3'd2) begin miscompares++; $display("FAIL b2b_two: got %0d want 2", infl[2:0]); end
    set_a(0, 1'b1, 1'b1, 3'd4, 2'd2, 2'd0, 32'h8, 4'hF);
    set_d(0, 1'b1, 1'b1, 3'd1, 2'd0);
    tick();
    idle();
    vectors++; if (err_flags !== 18'h0 || infl[2:0] !== 3'd2) begin miscompares++; $display("FAIL b2b_retire_alloc: got %h/%0d want 0/2", err_flags, infl[2:0]); end
    set_a(0, 1'b1, 1'b1, 3'd0, 2'd2, 2'd3, 32'h10, 4'hF);
    set_d(0, 1'b1, 1'b1, 3'd0, 2'd3);
    tick();
    idle();
    vectors++; if (err_flags !== 18'h0 || infl[2:0] !== 3'd2) begin miscompares++; $display("FAIL b2b_zero_lat: got %h/%0d want 0/2", err_flags, infl[2:0]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if (err_flags !== 18'h0 || infl !== 6'h0 || {err_any, fev, fep, fec} !== 7'h0) begin miscompares++; $display("FAIL b2b_reset: got %h/%h/%b want all 0", err_flags, infl, {err_any, fev, fep, fec}); end
    set_d(0, 1'b1, 1'b1, 3'd0, 2'd1);
    tick();
    idle();
    vectors++; if (err_flags !== 18'h040) begin miscompares++; $display("FAIL b2b_forgotten: got %h want 00040", err_flags); end
  endtask

  initial begin
    err_clear = 1'b0;
    reset = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_unstable();
    test_align_mask();
    test_opcode_priority();
    test_dup_noreq_clear();
    test_timeout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
